// File: rtl/out_channel.sv
// Buffered output channel: circular word buffer between the
// interpreter's out instruction and a valid/ready consumer.
module out_channel #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 2000,
  parameter int CW                 = $clog2(NOut + 1)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          run,
  input  logic                          finished,
  input  logic                          outValid,
  input  logic [MemoryElementWidth-1:0] outData,
  output logic                          outReady,
  output logic                          rdValid,
  output logic [MemoryElementWidth-1:0] rdData,
  input  logic                          rdReady,
  output logic [CW-1:0]                 count,
  output logic [31:0]                   written,
  output logic                          overflow,
  output logic                          drained
);

  localparam int PW = (NOut > 2) ? $clog2(NOut) : 1;
  localparam logic [PW-1:0] PtrLast = PW'(NOut - 1);
  localparam logic [CW-1:0] CntFull = CW'(NOut);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [31:0]             written_q, written_d;
  logic                    ovf_q, ovf_d;
  logic [MemoryElementWidth-1:0] mem_q [NOut];

  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;

  assign full     = (count_q == CntFull);
  assign empty    = (count_q == '0);
  assign outReady = (state_q == RUN) && !full;
  assign rdValid  = (state_q != IDLE) && !empty;
  assign rdData   = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign written  = written_q;
  assign overflow = ovf_q;
  assign drained  = (state_q == DONE);

  // run wins over any transfer in the same cycle
  assign wr_en = outValid && outReady && !run;
  assign rd_en = rdValid && rdReady && !run;

  // next state, pointers, counters; run restarts everything
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    written_d = written_q;
    ovf_d     = ovf_q;
    if (run) begin
      state_d   = RUN;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      written_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d  = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        written_d = written_q + 32'd1;
      end
      if (rd_en) begin
        rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
      if ((state_q == RUN) && outValid && full) begin
        ovf_d = 1'b1;
      end
      unique case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (finished) state_d = DRAIN;
        DRAIN:   if (empty) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // control registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      written_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      written_q <= written_d;
      ovf_q     <= ovf_d;
    end
  end

  // buffer storage; contents survive reset, pointers define validity
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= outData;
    end
  end

endmodule

// File: tb/tb_out_channel.sv
// Scoreboard bench for out_channel with a 4-deep buffer.
// Model tracks state, occupancy, write count and overflow.
module tb_out_channel;

  localparam int W  = 12;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          finished = 1'b0;
  logic          outValid = 1'b0;
  logic [W-1:0]  outData = '0;
  logic          rdReady = 1'b0;
  logic          outReady;
  logic          rdValid;
  logic [W-1:0]  rdData;
  logic [CW-1:0] count;
  logic [31:0]   written;
  logic          overflow;
  logic          drained;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] sb[$];
  int   mst;
  int   mcnt;
  int   mwr;
  logic movf;
  int   nreads;

  always #5 clock = ~clock;

  out_channel #(
    .MemoryElementWidth(W),
    .NOut(N)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .run(run),
    .finished(finished),
    .outValid(outValid),
    .outData(outData),
    .outReady(outReady),
    .rdValid(rdValid),
    .rdData(rdData),
    .rdReady(rdReady),
    .count(count),
    .written(written),
    .overflow(overflow),
    .drained(drained)
  );

  task automatic model_clear();
    mcnt = 0;
    mwr  = 0;
    movf = 1'b0;
    sb.delete();
  endtask

  task automatic check_regs(input string tag);
    checks++;
    if (count !== CW'(mcnt))
      $display("FAIL %s count: got %0d want %0d", tag, count, mcnt);
    if (count !== CW'(mcnt)) errors++;
    checks++;
    if (written !== 32'(mwr)) begin
      errors++;
      $display("FAIL %s written: got %0d want %0d", tag, written, mwr);
    end
    checks++;
    if (overflow !== movf) begin
      errors++;
      $display("FAIL %s overflow: got %b want %b", tag, overflow, movf);
    end
    checks++;
    if (drained !== (mst == 3)) begin
      errors++;
      $display("FAIL %s drained: got %b want %b", tag, drained, mst == 3);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic rr, input logic fin);
    logic wa, ra;
    logic [W-1:0] exp;
    outValid = v;
    outData  = d;
    rdReady  = rr;
    finished = fin;
    run      = 1'b0;
    #1;
    checks++;
    if (outReady !== (mst == 1 && mcnt != N)) begin
      errors++;
      $display("FAIL step outReady: got %b want %b",
               outReady, mst == 1 && mcnt != N);
    end
    checks++;
    if (rdValid !== (mst != 0 && mcnt != 0)) begin
      errors++;
      $display("FAIL step rdValid: got %b want %b",
               rdValid, mst != 0 && mcnt != 0);
    end
    wa = v && mst == 1 && mcnt != N;
    ra = rr && mst != 0 && mcnt != 0;
    if (v && mst == 1 && mcnt == N) movf = 1'b1;
    if (ra) begin
      exp = sb.pop_front();
      nreads++;
      checks++;
      if (rdData !== exp) begin
        errors++;
        $display("FAIL rdData: got %0d want %0d", rdData, exp);
      end
    end
    if (wa) begin
      sb.push_back(d);
      mwr++;
    end
    case (mst)
      1: if (fin) mst = 2;
      2: if (mcnt == 0) mst = 3;
      default: ;
    endcase
    mcnt = mcnt + int'(wa) - int'(ra);
    @(posedge clock);
    #1;
    outValid = 1'b0;
    rdReady  = 1'b0;
    finished = 1'b0;
    check_regs("step");
  endtask

  task automatic do_run(input logic v, input logic rr);
    run      = 1'b1;
    outValid = v;
    outData  = 12'hABC;
    rdReady  = rr;
    finished = 1'b1;
    @(posedge clock);
    #1;
    run      = 1'b0;
    outValid = 1'b0;
    rdReady  = 1'b0;
    finished = 1'b0;
    mst = 1;
    model_clear();
    check_regs("run");
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mst = 0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      run      = i[0];
      outValid = 1'b1;
      outData  = 12'(i + 5);
      rdReady  = 1'b1;
      finished = i[1];
      @(posedge clock);
      #1;
      checks++;
      if (outReady !== 1'b0 || rdValid !== 1'b0) begin
        errors++;
        $display("FAIL reset hs: got %b%b want 00", outReady, rdValid);
      end
      check_regs("reset");
    end
    run = 1'b0;
    outValid = 1'b0;
    rdReady = 1'b0;
    finished = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 12'd9, 1'b1, 1'b1);
    step(1'b1, 12'd9, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    do_run(1'b0, 1'b0);
    nreads = 0;
    step(1'b1, 12'd1, 1'b0, 1'b0);
    step(1'b1, 12'd2, 1'b0, 1'b0);
    step(1'b0, 12'd0, 1'b1, 1'b1);
    step(1'b0, 12'd0, 1'b1, 1'b0);
    step(1'b0, 12'd0, 1'b1, 1'b0);
    checks++;
    if (drained !== 1'b1 || nreads != 2 || written !== 32'd2) begin
      errors++;
      $display("FAIL basic end: drained %b reads %0d written %0d want 1 2 2",
               drained, nreads, written);
    end
  endtask

  task automatic test_overflow();
    do_run(1'b0, 1'b0);
    nreads = 0;
    for (int i = 0; i < 5; i++)
      step(1'b1, 12'(100 + i), 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== CW'(4) || outReady !== 1'b0) begin
      errors++;
      $display("FAIL ovf full: ovf %b count %0d rdy %b want 1 4 0",
               overflow, count, outReady);
    end
    step(1'b1, 12'd7, 1'b1, 1'b0);
    step(1'b0, 12'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      step(1'b0, 12'd0, 1'b1, 1'b0);
    checks++;
    if (nreads != 4 || drained !== 1'b1) begin
      errors++;
      $display("FAIL ovf drain: reads %0d drained %b want 4 1",
               nreads, drained);
    end
  endtask

  task automatic test_wrap();
    do_run(1'b0, 1'b0);
    nreads = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 12'(i), 1'b1, 1'b0);
      checks++;
      if (count > CW'(1)) begin
        errors++;
        $display("FAIL wrap count: got %0d want <=1", count);
      end
    end
    step(1'b0, 12'd0, 1'b1, 1'b1);
    step(1'b0, 12'd0, 1'b1, 1'b0);
    checks++;
    if (nreads != 10 || written !== 32'd10 || drained !== 1'b1) begin
      errors++;
      $display("FAIL wrap end: reads %0d written %0d drained %b want 10 10 1",
               nreads, written, drained);
    end
  endtask

  task automatic test_restart();
    do_run(1'b0, 1'b0);
    step(1'b1, 12'd31, 1'b0, 1'b0);
    step(1'b1, 12'd32, 1'b0, 1'b0);
    step(1'b1, 12'd33, 1'b0, 1'b1);
    checks++;
    if (count !== CW'(3) || drained !== 1'b0) begin
      errors++;
      $display("FAIL restart pre: count %0d drained %b want 3 0",
               count, drained);
    end
    do_run(1'b1, 1'b1);
    checks++;
    if (rdValid !== 1'b0 || outReady !== 1'b1) begin
      errors++;
      $display("FAIL restart state: rdValid %b outReady %b want 0 1",
               rdValid, outReady);
    end
    nreads = 0;
    step(1'b1, 12'd7, 1'b0, 1'b0);
    step(1'b0, 12'd0, 1'b1, 1'b0);
    checks++;
    if (nreads != 1) begin
      errors++;
      $display("FAIL restart read: reads %0d want 1", nreads);
    end
  endtask

  task automatic test_async_reset();
    do_run(1'b0, 1'b0);
    step(1'b1, 12'd50, 1'b0, 1'b0);
    step(1'b1, 12'd51, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    mst = 0;
    model_clear();
    checks++;
    if (rdValid !== 1'b0 || outReady !== 1'b0) begin
      errors++;
      $display("FAIL async hs: rdValid %b outReady %b want 0 0",
               rdValid, outReady);
    end
    check_regs("async");
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 12'd60, 1'b1, 1'b0);
    checks++;
    if (drained !== 1'b0 || outReady !== 1'b0) begin
      errors++;
      $display("FAIL async idle: drained %b outReady %b want 0 0",
               drained, outReady);
    end
  endtask

  initial begin
    mst = 0;
    nreads = 0;
    model_clear();
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
